// File: rtl/fc_layer_seq_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer:
// FSM state encoding, width helper and the ReLU/saturation function.
package fc_layer_seq_pkg;

  localparam int DEF_LANES = 128;
  localparam int DEF_DW    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_POST,
    S_WRITE,
    S_DONE
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  function automatic logic signed [63:0] relu_sat(input logic signed [63:0] v,
                                                  input int dw,
                                                  input logic relu);
    logic signed [63:0] hi, lo, r;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    r  = (relu && (v < 64'sd0)) ? 64'sd0 : v;
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/fc_layer_seq_requant.sv
// Combinational requantiser: arithmetic shift, optional ReLU, saturation to DW
// bits, plus a flag when saturation actually clipped the value.
module fc_requant
  import fc_layer_seq_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int DW    = DEF_DW,
  parameter int SHIFT = 4,
  parameter int RELU  = 1
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [DW-1:0]    q_o,
  output logic                    sat_o
);

  logic signed [63:0] wide, shifted, relued, clipped;

  always_comb begin
    wide    = 64'(acc_i);
    shifted = wide >>> SHIFT;
    relued  = ((RELU != 0) && (shifted < 64'sd0)) ? 64'sd0 : shifted;
    clipped = relu_sat(shifted, DW, RELU != 0);
    q_o     = clipped[DW-1:0];
    sat_o   = (clipped != relued);
  end

endmodule

// File: rtl/fc_layer_seq.sv
// Fully-connected layer sequencer: streams weight/activation words into an
// external MultAdder, accumulates per neuron, requantises and packs bytes.
module fc_layer_seq
  import fc_layer_seq_pkg::*;
#(
  parameter int LANES       = DEF_LANES,
  parameter int DW          = DEF_DW,
  parameter int IN_WORDS    = 7,
  parameter int OUT_NEURONS = 128,
  parameter int MA_W        = 15,
  parameter int ACC_W       = 24,
  parameter int SHIFT       = 4,
  parameter int RELU        = 1,
  parameter int ROM_AW      = 32,
  parameter int RAM_AW      = 3
) (
  input  logic                    clk,
  input  logic                    iRst_n,
  input  logic                    ena,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [ROM_AW-1:0]       addr_to_rom,
  output logic [RAM_AW-1:0]       addr_to_ram,
  input  logic [LANES*DW-1:0]     data_from_rom,
  input  logic [LANES*DW-1:0]     data_from_ram,
  output logic [LANES*DW-1:0]     opr1_to_MultAdder,
  output logic [LANES*DW-1:0]     opr2_to_MultAdder,
  input  logic signed [MA_W-1:0]  data_from_MultAdder,
  input  logic                    overflow_from_MultAdder,
  output logic                    wr_en,
  output logic [RAM_AW-1:0]       wr_addr,
  output logic [LANES*DW-1:0]     data_to_ram
);

  localparam int WW = cnt_w(IN_WORDS);
  localparam int LW = cnt_w(LANES);
  localparam int NW = cnt_w(OUT_NEURONS + 1);

  state_e                        state_q, state_d;
  logic [WW-1:0]                 w_q, w_d;
  logic [NW-1:0]                 n_q, n_d;
  logic [ROM_AW-1:0]             base_q, base_d;
  logic [LW-1:0]                 lane_q, lane_d;
  logic [RAM_AW-1:0]             wa_q, wa_d;
  logic [LANES-1:0][DW-1:0]      buf_q, buf_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic                          ovf_q, ovf_d;
  logic                          v1_q, v1_d;
  logic                          v2_q, v2_d;
  logic [LANES*DW-1:0]           opr1_q, opr1_d;
  logic [LANES*DW-1:0]           opr2_q, opr2_d;

  logic signed [ACC_W-1:0]       ma_ext, acc_sum;
  logic                          acc_wrap;
  logic [DW-1:0]                 rq;
  logic                          rq_sat;

  fc_requant #(
    .ACC_W (ACC_W),
    .DW    (DW),
    .SHIFT (SHIFT),
    .RELU  (RELU)
  ) u_requant (
    .acc_i (acc_q),
    .q_o   (rq),
    .sat_o (rq_sat)
  );

  assign ma_ext   = ACC_W'(data_from_MultAdder);
  assign acc_sum  = acc_q + ma_ext;
  assign acc_wrap = (acc_q[ACC_W-1] == ma_ext[ACC_W-1]) &&
                    (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

  assign addr_to_rom       = base_q + ROM_AW'(w_q);
  assign addr_to_ram       = RAM_AW'(w_q);
  assign opr1_to_MultAdder = opr1_q;
  assign opr2_to_MultAdder = opr2_q;
  assign busy              = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done              = (state_q == S_DONE);
  assign overflow          = ovf_q;
  assign wr_en             = (state_q == S_WRITE) && ena;
  assign wr_addr           = wa_q;
  assign data_to_ram       = buf_q;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    n_d     = n_q;
    base_d  = base_q;
    lane_d  = lane_q;
    wa_d    = wa_q;
    buf_d   = buf_q;
    // Two-stage pipe: v1 = ROM/RAM data valid now, v2 = operands valid now.
    v1_d    = 1'b0;
    v2_d    = v1_q;
    opr1_d  = v1_q ? data_from_rom : opr1_q;
    opr2_d  = v1_q ? data_from_ram : opr2_q;
    acc_d   = v2_q ? acc_sum : acc_q;
    ovf_d   = ovf_q | (v2_q & (overflow_from_MultAdder | acc_wrap));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = '0;
          w_d     = '0;
          base_d  = '0;
          lane_d  = '0;
          wa_d    = '0;
          buf_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        v1_d = 1'b1;
        if (w_q == WW'(IN_WORDS - 1)) begin
          w_d     = '0;
          state_d = S_DRAIN;
        end else begin
          w_d = w_q + WW'(1);
        end
      end
      S_DRAIN: begin
        // w is reused as the two-cycle drain counter
        if (w_q == WW'(1)) begin
          w_d     = '0;
          state_d = S_POST;
        end else begin
          w_d = w_q + WW'(1);
        end
      end
      S_POST: begin
        buf_d[lane_q] = rq;
        ovf_d         = ovf_q | rq_sat;
        n_d           = n_q + NW'(1);
        base_d        = base_q + ROM_AW'(IN_WORDS);
        acc_d         = '0;
        if ((lane_q == LW'(LANES - 1)) || (n_q == NW'(OUT_NEURONS - 1))) begin
          lane_d  = '0;
          state_d = S_WRITE;
        end else begin
          lane_d  = lane_q + LW'(1);
          state_d = S_FETCH;
        end
      end
      S_WRITE: begin
        buf_d   = '0;
        wa_d    = wa_q + RAM_AW'(1);
        state_d = (n_q == NW'(OUT_NEURONS)) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      lane_q  <= '0;
      wa_q    <= '0;
      buf_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      opr1_q  <= '0;
      opr2_q  <= '0;
    end else if (ena) begin
      state_q <= state_d;
      w_q     <= w_d;
      n_q     <= n_d;
      base_q  <= base_d;
      lane_q  <= lane_d;
      wa_q    <= wa_d;
      buf_q   <= buf_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      opr1_q  <= opr1_d;
      opr2_q  <= opr2_d;
    end
  end

endmodule

// File: doc/fc_layer_seq.md
# fc_layer_seq

Parametrised fully-connected layer sequencer for the TPU datapath. Streams weight words from ROM and activation words from RAM into the external MultAdder, accumulates per-neuron partial dot products, then requantises, applies ReLU and saturates. Results are packed one byte per neuron into RAM output words. It generalises the fixed single-layer controller to any lane count, input length and neuron count, and adds start/busy/done handshaking, clock-enable freeze, requantisation, saturation and partial-word writeback.

## Interface
- LANES, 128: operand lanes per ROM/RAM word and per MultAdder call.
- DW, 8: signed lane width; also the output byte width.
- IN_WORDS, 7: input words per neuron (≥1).
- OUT_NEURONS, 128: neurons computed per run (≥1).
- MA_W, 15: signed MultAdder result width.
- ACC_W, 24: signed accumulator width (> MA_W).
- SHIFT, 4: arithmetic right shift applied at requantisation.
- RELU, 1: 1 clamps negative results to 0.
- ROM_AW, 32 / RAM_AW, 3: address widths.

Ports:
- clk  in  1  clock, rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- ena  in  1  clock enable; when low, all state is frozen.
- start  in  1  one-cycle run request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at run end.
- overflow  out  1  sticky error flag; cleared on start.
- addr_to_rom  out  ROM_AW  weight word address = n*IN_WORDS + w.
- addr_to_ram  out  RAM_AW  activation word address = w.
- data_from_rom / data_from_ram  in  LANES*DW  synchronous-read data, valid 1 cycle after the address.
- opr1_to_MultAdder / opr2_to_MultAdder  out  LANES*DW  registered weight/activation operands.
- data_from_MultAdder  in  MA_W  combinational dot product of the current operands.
- overflow_from_MultAdder  in  1  MultAdder overflow for the current operands.
- wr_en  out  1  output-word write strobe.
- wr_addr  out  RAM_AW  output word index = n / LANES.
- data_to_ram  out  LANES*DW  packed output word; lane k holds neuron wr_addr*LANES + k.

## Operation
- States: IDLE → FETCH → DRAIN → POST → (WRITE) → FETCH … → DONE → IDLE.
- IDLE: start=1 clears the accumulator, neuron counter n, word counter w, the pack buffer and overflow. Next state is FETCH.
- FETCH (IN_WORDS cycles): issues an address pair each cycle with w = 0..IN_WORDS-1.
  - Stage 2: the opr registers capture ROM/RAM data one cycle after the address.
  - Stage 3: one cycle later, the accumulator adds sign-extended data_from_MultAdder.
- DRAIN (2 cycles): empties the two pipeline stages.
- POST (1 cycle): computes r = acc >>> SHIFT; if RELU, negative r becomes 0; r then saturates to [-2^(DW-1), 2^(DW-1)-1].
  - The result goes to pack-buffer lane n mod LANES.
  - n increments and the accumulator clears.
  - Next state is WRITE if the lane was LANES-1 or n was the last neuron; otherwise FETCH.
- WRITE (1 cycle): wr_en=1 with the current buffer and wr_addr. Unfilled lanes are 0. The buffer clears afterwards. Next state is DONE after the last neuron, otherwise FETCH.
- DONE (1 cycle): done=1, busy=0. Next state is IDLE.
- overflow sets on any of: overflow_from_MultAdder in an accumulate cycle; signed accumulator overflow (the accumulator wraps); saturation in POST. It holds until the next accepted start.
- start while not in IDLE is ignored.
- ena=0: no register changes and wr_en is forced to 0. Operation resumes exactly where it stopped.

## Timing
- Reset: every output is 0. State is IDLE and all counters and buffers are 0.
- Reset mid-run aborts the run immediately; no partial write is issued.
- Latency with ena held high, where edge 0 is the edge that samples start: done is high in cycle OUT_NEURONS*(IN_WORDS+3) + ceil(OUT_NEURONS/LANES) + 1.
- Each ena-low cycle during a run adds exactly one cycle to that latency.
- The MultAdder result is used in the same cycle its operands are presented; there is no MultAdder register.

## Structure
- A shared package holds: the state enum; the clog2 helper; the saturate/ReLU function; the default lane and data widths.
- A natural sub-module is fc_requant (shift, ReLU, saturate, and a saturation flag), which is combinational and tested standalone.

## Test plan
- Defaults, ROM bytes 0x01, RAM bytes 0x02, MultAdder model returns the true dot product (256 per word).
  - Required: acc 1792 → 112.
  - One write, wr_addr 0, all bytes 0x70, overflow 0, done in cycle 1282.
- ROM bytes 0xFF, RAM bytes 0x02 (−256 per word), RELU=1 → all bytes 0x00, overflow 0.
- MultAdder driven to constant 16383 → acc 114681, shifted 7167 → saturates to 0x7F; overflow=1 until the next start.
- OUT_NEURONS=130, all else as the first test.
  - Required: two writes. wr_addr 0 has all bytes 0x70. wr_addr 1 has lanes 0–1 = 0x70 and the rest 0. done in cycle 1303.
- ena low for 10 cycles during FETCH of neuron 5 → identical outputs, done 10 cycles later, no wr_en while ena is low.
- iRst_n low mid-run, then a new start → all outputs 0 during reset, no stale write, and the fresh run matches the first test.
